add_out_stage: RTL

//  Registered output stage directly downstream of the N-bit ripple adder.
//  - Captures each adder result (s, cout) under a valid/ready handshake and holds it in a 2-entry skid buffer.
//  - Computes status flags zero, negative and signed overflow at capture time.
//  - Presents results in order to the consumer. It is the first clocked point after the combinational adder path.

---
 rtl/add_pkg.sv | 13 +
 rtl/add_flags.sv | 21 ++
 rtl/add_out_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the adder output stages: skid-buffer occupancy
// state codes and the default adder result width.
package add_pkg;

    // Skid-buffer occupancy states (number of entries held)
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Default adder result width
    localparam int ADD_W = 64;

endpackage

// File: rtl/add_flags.sv
// Combinational status flags for an N-bit adder result.
//   z : sum is zero (carry out is not part of the test)
//   n : sum sign bit
//   v : signed overflow, i.e. both operands share a sign that the sum lost
// Shared by the output stages of every adder width.
module add_flags #(
    parameter int N = 64
) (
    input  logic [N-1:0] s,
    input  logic         a_msb,
    input  logic         b_msb,
    output logic         z,
    output logic         n,
    output logic         v
);

    assign z = (s == {N{1'b0}});
    assign n = s[N-1];
    assign v = (a_msb == b_msb) && (s[N-1] != a_msb);

endmodule

// File: rtl/add_out_stage.sv
// Registered output stage behind the N-bit ripple adder.
// Captures {sum, carry, z, n, v} under a valid/ready handshake into a
// 2-entry skid buffer and presents entries in FIFO order. in_ready is
// decoded from the registered occupancy only, so the consumer's
// out_ready never reaches the producer combinationally.
// Optional build macro: ADD_OUT_STATS_EN adds stat_clr / stat_xfer /
// stat_ovf saturating transfer and overflow counters.
module add_out_stage
    import add_pkg::*;
#(
    parameter int N  = ADD_W,
    parameter int CW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] s,
    input  logic         cout,
    input  logic         a_msb,
    input  logic         b_msb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_s,
    output logic         out_cout,
    output logic         out_z,
    output logic         out_n,
    output logic         out_v
`ifdef ADD_OUT_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [CW-1:0] stat_xfer,
    output logic [CW-1:0] stat_ovf
`endif
);

    // Elaboration-time parameter sanity
    if (N < 2) begin : g_bad_n
        $error("add_out_stage: N must be >= 2");
    end
    if (CW < 2) begin : g_bad_cw
        $error("add_out_stage: CW must be >= 2");
    end

    typedef struct packed {
        logic [N-1:0] s;
        logic         cout;
        logic         z;
        logic         n;
        logic         v;
    } entry_t;

    logic       z_s;
    logic       n_s;
    logic       v_s;
    entry_t     in_entry_s;
    entry_t     head_r;
    entry_t     tail_r;
    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       push_s;
    logic       pop_s;

    add_flags #(.N(N)) u_flags (
        .s     (s),
        .a_msb (a_msb),
        .b_msb (b_msb),
        .z     (z_s),
        .n     (n_s),
        .v     (v_s)
    );

    assign in_entry_s = '{s: s, cout: cout, z: z_s, n: n_s, v: v_s};
    assign push_s     = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next occupancy from the push/pop handshakes
    always_comb begin
        state_nxt_s = ST_EMPTY;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && !pop_s) begin
                    state_nxt_s = ST_TWO;
                end else if (pop_s && !push_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (pop_s) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_TWO;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ST_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            ST_TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
        endcase
    end

    // Entry storage: head is what the consumer sees, tail is the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_r <= in_entry_s;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_r <= in_entry_s;
                    end else if (push_s) begin
                        tail_r <= in_entry_s;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        head_r <= tail_r;
                    end
                end
                default: begin
                    head_r <= '0;
                    tail_r <= '0;
                end
            endcase
        end
    end

    assign out_s    = head_r.s;
    assign out_cout = head_r.cout;
    assign out_z    = head_r.z;
    assign out_n    = head_r.n;
    assign out_v    = head_r.v;

`ifdef ADD_OUT_STATS_EN
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] xfer_r;
    logic [CW-1:0] ovf_r;

    // Saturating counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_r <= {CW{1'b0}};
            ovf_r  <= {CW{1'b0}};
        end else if (stat_clr) begin
            xfer_r <= {CW{1'b0}};
            ovf_r  <= {CW{1'b0}};
        end else begin
            if (pop_s && (xfer_r != CNT_MAX)) begin
                xfer_r <= xfer_r + CNT_ONE;
            end
            if (push_s && v_s && (ovf_r != CNT_MAX)) begin
                ovf_r <= ovf_r + CNT_ONE;
            end
        end
    end

    assign stat_xfer = xfer_r;
    assign stat_ovf  = ovf_r;
`endif

endmodule
